// File: rtl/mac_sched_pkg.sv
// Shared constants and tag type for the round-robin MAC scheduler.
package mac_sched_pkg;

  localparam int A_W      = 18;
  localparam int B_W      = 18;
  localparam int C_W      = 48;
  localparam int MAX_NREQ = 8;
  localparam int ID_MAX_W = 3;

  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] id;
  } tag_t;

  function automatic int next_id(input int id, input int n);
    return (id + 1) % n;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from the pointer, grants one requester, then
// moves the pointer just past the winner.
module rr_arbiter
  import mac_sched_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            adv,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id
);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic           found_s;
  int             idx_s;

  // first requester at or after the pointer wins
  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    found_s = 1'b0;
    idx_s   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx_s = (int'(ptr_q) + k) % NREQ;
      if (!found_s && req[idx_s]) begin
        gnt[idx_s] = 1'b1;
        gnt_id     = idx_s[IDW-1:0];
        found_s    = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
    if (adv && found_s) begin
      ptr_d = IDW'(next_id(int'(gnt_id), NREQ));
    end else begin
      ptr_d = ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mac_rr_sched.sv
// Time-shares one A*B+C MAC between NREQ requesters; a tag pipeline matched to
// the MAC latency routes each result back to the requester that issued it.
module mac_rr_sched
  import mac_sched_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int MAC_LAT = 2,
  parameter int IDW     = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*18-1:0] req_a,
  input  logic [NREQ*18-1:0] req_b,
  input  logic [NREQ*48-1:0] req_c,
  output logic [A_W-1:0]    mac_a,
  output logic [B_W-1:0]    mac_b,
  output logic [C_W-1:0]    mac_c,
  input  logic [C_W-1:0]    mac_z,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [C_W-1:0]    rsp_z,
  output logic [2:0]        inflight,
  output logic              busy
);

  localparam int NST = MAC_LAT + 1;

  logic [NREQ-1:0] gnt_s;
  logic [IDW-1:0]  gnt_id_s;
  logic            fire_s;
  tag_t            last_s;

  logic [A_W-1:0]  mac_a_q, mac_a_d;
  logic [B_W-1:0]  mac_b_q, mac_b_d;
  logic [C_W-1:0]  mac_c_q, mac_c_d;
  logic [C_W-1:0]  rsp_z_q, rsp_z_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [2:0]      inflight_q, inflight_d;
  tag_t            tag_q [NST];
  tag_t            tag_d [NST];

  // A grant is only ever given to a requesting port, so every grant transfers.
  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (req_valid),
    .adv    (1'b1),
    .gnt    (gnt_s),
    .gnt_id (gnt_id_s)
  );

  assign fire_s    = |gnt_s;
  assign req_ready = gnt_s;
  assign last_s    = tag_q[NST-1];

  always_comb begin
    mac_a_d = mac_a_q;
    mac_b_d = mac_b_q;
    mac_c_d = mac_c_q;
    tag_d[0] = '0;
    if (fire_s) begin
      mac_a_d  = req_a[int'(gnt_id_s)*A_W +: A_W];
      mac_b_d  = req_b[int'(gnt_id_s)*B_W +: B_W];
      mac_c_d  = req_c[int'(gnt_id_s)*C_W +: C_W];
      tag_d[0] = '{valid: 1'b1, id: ID_MAX_W'(gnt_id_s)};
    end else begin
      tag_d[0] = '0;
    end
    for (int s = 1; s < NST; s++) begin
      tag_d[s] = tag_q[s-1];
    end
  end

  // results are steered from the last tag stage in the cycle mac_z is valid
  always_comb begin
    rsp_valid = '0;
    rsp_id    = rsp_id_q;
    rsp_z     = rsp_z_q;
    rsp_id_d  = rsp_id_q;
    rsp_z_d   = rsp_z_q;
    if (last_s.valid) begin
      for (int i = 0; i < NREQ; i++) begin
        rsp_valid[i] = (last_s.id == ID_MAX_W'(i));
      end
      rsp_id   = last_s.id[IDW-1:0];
      rsp_z    = mac_z;
      rsp_id_d = last_s.id[IDW-1:0];
      rsp_z_d  = mac_z;
    end else begin
      rsp_valid = '0;
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    case ({fire_s, last_s.valid})
      2'b10: begin
        if (inflight_q != 3'd7) begin
          inflight_d = inflight_q + 3'd1;
        end else begin
          inflight_d = inflight_q;
        end
      end
      2'b01: begin
        if (inflight_q != 3'd0) begin
          inflight_d = inflight_q - 3'd1;
        end else begin
          inflight_d = inflight_q;
        end
      end
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mac_a_q    <= '0;
      mac_b_q    <= '0;
      mac_c_q    <= '0;
      rsp_z_q    <= '0;
      rsp_id_q   <= '0;
      inflight_q <= 3'd0;
      for (int s = 0; s < NST; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      mac_a_q    <= mac_a_d;
      mac_b_q    <= mac_b_d;
      mac_c_q    <= mac_c_d;
      rsp_z_q    <= rsp_z_d;
      rsp_id_q   <= rsp_id_d;
      inflight_q <= inflight_d;
      for (int s = 0; s < NST; s++) begin
        tag_q[s] <= tag_d[s];
      end
    end
  end

  assign mac_a    = mac_a_q;
  assign mac_b    = mac_b_q;
  assign mac_c    = mac_c_q;
  assign inflight = inflight_q;
  assign busy     = (inflight_q != 3'd0) || tag_q[0].valid;

endmodule

// File: tb/tb_mac_rr_sched.sv
// Bench for mac_rr_sched: a queue-based scoreboard checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_mac_rr_sched;

  localparam int NREQ    = 2;
  localparam int MAC_LAT = 2;
  localparam int IDW     = 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*18-1:0] req_a;
  logic [NREQ*18-1:0] req_b;
  logic [NREQ*48-1:0] req_c;
  logic [17:0]       mac_a;
  logic [17:0]       mac_b;
  logic [47:0]       mac_c;
  logic [47:0]       mac_z;
  logic [NREQ-1:0]   rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [47:0]       rsp_z;
  logic [2:0]        inflight;
  logic              busy;

  int n_vec = 0;
  int n_bad = 0;

  mac_rr_sched #(.NREQ(NREQ), .MAC_LAT(MAC_LAT), .IDW(IDW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c), .mac_z(mac_z),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_z(rsp_z),
    .inflight(inflight), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [47:0] mac_fn(input logic [17:0] a, input logic [17:0] b,
                                         input logic [47:0] c);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b)) + longint'(c);
    return p[47:0];
  endfunction

  // Behavioural MAC with MAC_LAT cycles of latency from mac_a/b/c to mac_z.
  logic [47:0] z_pipe [MAC_LAT];
  always @(posedge clk) begin
    z_pipe[0] <= mac_fn(mac_a, mac_b, mac_c);
    for (int s = 1; s < MAC_LAT; s++) z_pipe[s] <= z_pipe[s-1];
  end
  assign mac_z = z_pipe[MAC_LAT-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  // Scoreboard: one entry per accepted request, due MAC_LAT+1 cycles later.
  typedef struct {
    int          due;
    int          id;
    logic [47:0] z;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          m_ptr = 0;
  int          m_infl = 0;
  bit          m_en = 1'b0;
  logic [17:0] m_a = '0, m_b = '0;
  logic [47:0] m_c = '0, m_last_z = '0;

  always @(negedge clk) begin
    int g;
    logic [NREQ-1:0] exp_ready, exp_rv;
    bit due_now;
    g = rr_pick(req_valid, m_ptr);
    due_now = (q.size() > 0) && (q[0].due == cyc);
    if (m_en) begin
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      chk("req_ready", req_ready, exp_ready);
      chk("mac_a", mac_a, m_a);
      chk("mac_b", mac_b, m_b);
      chk("mac_c", mac_c, m_c);
      if (due_now) begin
        exp_rv = '0;
        exp_rv[q[0].id] = 1'b1;
        chk("rsp_valid", rsp_valid, exp_rv);
        chk("rsp_id", rsp_id, q[0].id);
        chk("rsp_z", rsp_z, q[0].z);
      end else begin
        chk("rsp_valid_idle", rsp_valid, 0);
        chk("rsp_z_hold", rsp_z, m_last_z);
      end
      chk("inflight", inflight, m_infl);
      chk("busy", busy, m_infl != 0);
    end
    if (reset) begin
      q.delete();
      m_ptr = 0; m_infl = 0; m_a = '0; m_b = '0; m_c = '0; m_last_z = '0;
      m_en = 1'b1;
    end else if (m_en) begin
      if (due_now) begin
        m_last_z = q[0].z;
        void'(q.pop_front());
        m_infl--;
      end
      if (g >= 0) begin
        m_a = req_a[18*g +: 18];
        m_b = req_b[18*g +: 18];
        m_c = req_c[48*g +: 48];
        q.push_back('{due: cyc + MAC_LAT + 1, id: g, z: mac_fn(m_a, m_b, m_c)});
        m_ptr = (g + 1) % NREQ;
        m_infl++;
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [17:0] a,
                         input logic [17:0] b, input logic [47:0] c);
    req_valid[i]       = v;
    req_a[18*i +: 18]  = a;
    req_b[18*i +: 18]  = b;
    req_c[48*i +: 48]  = c;
  endtask

  initial begin
    int peak;
    int nrsp;
    int zsum;
    reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_c = '0;
    repeat (3) step();
    reset = 1'b0;
    step();

    // 1: single op from requester 1, 3 * -4 + 100 = 88
    set_req(1, 1'b1, 18'd3, 18'h3FFFC, 48'd100);
    @(negedge clk) chk("t1_ready", req_ready, 2'b10);
    step();
    req_valid = '0;
    @(negedge clk);
    chk("t1_mac_a", mac_a, 18'd3);
    chk("t1_mac_b", mac_b, 18'h3FFFC);
    chk("t1_mac_c", mac_c, 48'd100);
    step(); step();
    @(negedge clk);
    chk("t1_rsp_valid", rsp_valid, 2'b10);
    chk("t1_rsp_id", rsp_id, 1'b1);
    chk("t1_rsp_z", rsp_z, 48'd88);
    repeat (2) step();

    // 2: both requesters continuously for 6 cycles
    set_req(0, 1'b1, 18'd5, 18'd7, 48'd1);
    set_req(1, 1'b1, 18'h3FFF0, 18'd9, 48'd1000);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk) chk("t2_grant", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      step();
    end
    req_valid = '0;
    repeat (5) step();

    // 3: fairness after idle
    set_req(0, 1'b1, 18'd1, 18'd1, 48'd0);
    step();
    req_valid = '0;
    set_req(1, 1'b1, 18'd2, 18'd2, 48'd0);
    @(negedge clk) chk("t3_lone1", req_ready, 2'b10);
    step();
    set_req(0, 1'b1, 18'd4, 18'd4, 48'd0);
    @(negedge clk) chk("t3_after1", req_ready, 2'b01);
    step();
    req_valid = '0;
    repeat (5) step();

    // 4: full-rate single requester, A=i, B=2, C=0
    peak = 0; nrsp = 0; zsum = 0;
    for (int i = 0; i < 15; i++) begin
      if (i < 10) set_req(0, 1'b1, 18'(i), 18'd2, 48'd0);
      else req_valid = '0;
      @(negedge clk);
      if (int'(inflight) > peak) peak = int'(inflight);
      if (rsp_valid[0]) begin
        nrsp++;
        zsum += int'(rsp_z);
      end
      step();
    end
    chk("t4_peak_inflight", peak, 3);
    chk("t4_rsp_count", nrsp, 10);
    chk("t4_rsp_sum", zsum, 90);
    repeat (2) step();

    // 5: reset one cycle after two issues
    set_req(0, 1'b1, 18'd11, 18'd3, 48'd5);
    step();
    step();
    req_valid = '0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("t5_inflight", inflight, 3'd0);
    chk("t5_busy", busy, 1'b0);
    chk("t5_mac_a", mac_a, 18'd0);
    chk("t5_mac_c", mac_c, 48'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk) chk("t5_no_rsp", rsp_valid, 2'b00);
      step();
    end

    // 6: operand extremes, (-2^17)^2 + 0x7FFF_FFFF_FFFF
    set_req(0, 1'b1, 18'h20000, 18'h20000, 48'h7FFF_FFFF_FFFF);
    step();
    req_valid = '0;
    step(); step();
    @(negedge clk);
    chk("t6_rsp_valid", rsp_valid, 2'b01);
    chk("t6_rsp_z", rsp_z, 48'h8003_FFFF_FFFF);
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk) chk("t6_rsp_z_hold", rsp_z, 48'h8003_FFFF_FFFF);
    end
    chk("t6_idle_busy", busy, 1'b0);
    repeat (2) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
